// File: rtl/apb_master_arb_if.sv
// Bundle of requester handshake and APB bus signals for apb_master_arb.
// The master modport is the arbiter side; slave is the agents/APB-slave side.
interface apb_master_arb_if #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_rdata;
  logic               resp_err;
  logic               busy;
  logic               psel;
  logic               pen;
  logic               pwrite;
  logic [31:0]        paddr;
  logic [31:0]        pwdata;
  logic [31:0]        prdata;
  logic               pready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           psel, pen, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           psel, pen, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_arb.sv
// Round-robin arbiter that sequences NREQ single-shot requesters onto one APB bus.
// Optional ACCESS-phase timeout is built in when APB_ARB_TIMEOUT_EN is defined.
module apb_master_arb #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input logic              clk,
  input logic              rstn,
  apb_master_arb_if.master bus
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    last_q, last_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic             write_q, write_d;
  logic             psel_q, psel_d;
  logic             pen_q, pen_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      paddr_q, paddr_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DW-1:0]    resp_rdata_q, resp_rdata_d;
  logic             busy_q, busy_d;
  logic [GW-1:0]    pick_s;
  logic [GW-1:0]    idx_s;
  logic             any_s;
  logic [AW-1:0]    addr_a  [NREQ];
  logic [DW-1:0]    wdata_a [NREQ];

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             resp_err_q, resp_err_d;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i]  = bus.req_addr[i*AW +: AW];
    assign wdata_a[i] = bus.req_wdata[i*DW +: DW];
  end

  // Round-robin pick: first pending requester after the last one granted.
  always_comb begin
    pick_s = last_q;
    idx_s  = last_q;
    any_s  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = GW'((int'(last_q) + k) % NREQ);
      if (!any_s && bus.req_valid[idx_s]) begin
        pick_s = idx_s;
        any_s  = 1'b1;
      end else begin
        any_s  = any_s;
      end
    end
  end

  // Accept strobe is combinational and only offered while idle.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == ST_IDLE && any_s) begin
      bus.req_ready[pick_s] = 1'b1;
    end else begin
      bus.req_ready = '0;
    end
  end

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    write_d      = write_q;
    psel_d       = psel_q;
    pen_d        = pen_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    resp_err_d   = resp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          state_d  = ST_SETUP;
          last_d   = pick_s;
          grant_d  = pick_s;
          write_d  = bus.req_write[pick_s];
          psel_d   = 1'b1;
          pen_d    = 1'b0;
          pwrite_d = bus.req_write[pick_s];
          paddr_d  = 32'(addr_a[pick_s]);
          pwdata_d = bus.req_write[pick_s] ? 32'(wdata_a[pick_s]) : 32'h0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        pen_d   = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_ACCESS: begin
        if (bus.pready) begin
          state_d               = ST_IDLE;
          psel_d                = 1'b0;
          pen_d                 = 1'b0;
          resp_valid_d[grant_q] = 1'b1;
          resp_rdata_d          = write_q ? '0 : DW'(bus.prdata);
`ifdef APB_ARB_TIMEOUT_EN
          resp_err_d            = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Slave never answered: abort with an error response.
          state_d               = ST_IDLE;
          psel_d                = 1'b0;
          pen_d                 = 1'b0;
          resp_valid_d[grant_q] = 1'b1;
          resp_rdata_d          = '0;
          resp_err_d            = 1'b1;
        end else begin
          cnt_d                 = cnt_q + CW'(1);
        end
`else
        end else begin
          state_d               = ST_ACCESS;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        psel_d  = 1'b0;
        pen_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // All sequencer state and bus outputs; reset restarts arbitration at requester 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      last_q       <= GW'(NREQ - 1);
      grant_q      <= '0;
      write_q      <= 1'b0;
      psel_q       <= 1'b0;
      pen_q        <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= 32'h0;
      pwdata_q     <= 32'h0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      busy_q       <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      write_q      <= write_d;
      psel_q       <= psel_d;
      pen_q        <= pen_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      busy_q       <= busy_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign bus.psel       = psel_q;
  assign bus.pen        = pen_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.busy       = busy_q;
`ifdef APB_ARB_TIMEOUT_EN
  assign bus.resp_err   = resp_err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Round-robin arbiter and APB master sequencer that shares one APB bus between NREQ testbench/agent requesters. Each requester posts a single read or write; the block grants one at a time, drives the APB SETUP/ACCESS phases, waits for pready and returns read data or completion to the granted requester. It sits between bench-side drivers and the DUT APB slave port, in place of direct `wr`/`rd` task calls when several agents share the bus.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 256, ACCESS-phase cycle limit (used only with APB_ARB_TIMEOUT_EN)

Ports (one clock `clk`; reset `rstn` is asynchronous, active-low):
- clk  in  1  clock
- rstn  in  1  async active-low reset
- req_valid  in  NREQ  request pending per requester; held until accepted
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- req_ready  out  NREQ  one-hot accept strobe, 1 cycle
- resp_valid  out  NREQ  one-hot completion strobe, 1 cycle
- resp_rdata  out  DW  read data, valid with resp_valid
- resp_err  out  1  timeout error, valid with resp_valid
- busy  out  1  transfer in progress (state != IDLE)
- psel, pen, pwrite  out  1  APB control
- paddr  out  32  APB address (AW bits zero-extended)
- pwdata  out  32  APB write data
- prdata  in  32  APB read data
- pready  in  1  APB ready

## Operation
- FSM: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE: if any req_valid, grant = first set bit searching from (last_grant+1) mod NREQ upward with wrap. req_ready[grant] = 1 combinationally in IDLE only. At that edge: latch addr/wdata/write of grant, record grant index, go SETUP.
- SETUP (1 cycle): psel=1, pen=0, paddr/pwrite/pwdata registered from latch; pwdata=0 for reads. Next: ACCESS.
- ACCESS: psel=1, pen=1; stay while pready=0. On edge with pready=1: capture prdata (reads; writes capture 0), go IDLE, resp_valid[grant]=1 next cycle.
- Back to IDLE: psel=pen=0; paddr/pwrite/pwdata hold last value.
- last_grant updates only on accept. Requester may drop req_valid before accept; no grant issued for a dropped request.
- A requester completing may re-request immediately; it ranks lowest next round.

## Timing
- Reset values: psel=pen=pwrite=0, paddr=pwdata=0, req_ready=0 (FSM IDLE, no req), resp_valid=0, resp_rdata=0, resp_err=0, busy=0, last_grant=NREQ-1 (requester 0 highest priority first).
- All APB outputs registered. Accept cycle T: psel rises T+1, pen rises T+2.
- pready=1 in first ACCESS cycle: resp_valid at T+3; next accept earliest T+3 (same cycle as resp_valid), psel again T+4. Minimum one idle cycle with psel=0 between transfers.
- Each pready-wait cycle adds 1 to latency.
- pready sampled only in ACCESS; ignored in IDLE/SETUP.
- Reset mid-transfer: psel/pen drop asynchronously; no resp_valid issued for aborted transfer; arbitration restarts at requester 0.

## Configuration
- APB_ARB_TIMEOUT_EN defined: counter clears on SETUP->ACCESS, increments each ACCESS cycle with pready=0; when count reaches TIMEOUT-1 with pready still 0, transfer terminates: go IDLE, resp_valid[grant]=1 with resp_err=1 and resp_rdata=0. pready=1 on the final cycle wins (normal completion, resp_err=0).
- Not defined: no counter, ACCESS waits indefinitely, resp_err tied 0, TIMEOUT ignored.

## Test plan
- Single write, req0 addr 0x10 data 0xA5A5_0001, pready=1 -> req_ready[0] at T, psel T+1, pen T+2 with paddr=0x10 pwdata=0xA5A5_0001 pwrite=1, resp_valid[0] at T+3, resp_err=0.
- Read req2 addr 0x04, pready held 0 for 3 ACCESS cycles, prdata=0x0000_00C3 -> pen high 4 cycles, resp_valid[2] at T+6, resp_rdata=0xC3, pwdata=0.
- All four requesters valid continuously after reset -> grant order 0,1,2,3,0; each psel burst separated by one psel=0 cycle.
- req1 and req3 valid after req1 just served -> req3 granted before req1.
- rstn pulled low during ACCESS of req0 -> psel/pen 0 immediately, no resp_valid; after release with req1 and req0 valid, req0 granted first.
- With APB_ARB_TIMEOUT_EN, TIMEOUT=8, pready stuck 0 -> pen high exactly 8 cycles, resp_valid with resp_err=1, resp_rdata=0; without macro, pen stays high until pready asserted.
